// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: accepts program words over valid/ready, zero-fills the rest of imem, then runs the CPU for RUN_CYCLES cycles.
// Latency: an accepted word appears on the imem write port one cycle after its transfer edge; fill writes follow one per cycle.
// Backpressure: load_ready_o is high only in LOAD and drops the cycle after the final (last or DEPTH-th) word, so extra words are never taken.
module imem_boot_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RUN_CYCLES = 30
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              start_o,
  output logic              done_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [15:0]       cycle_count_o,
  output logic              overflow_o
);

  localparam int WC_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FILL = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [WC_W-1:0]   r_wc;
  logic [15:0]       r_cycle;
  logic              r_ovf;

  logic              w_load_ready;
  logic              w_start;
  logic              w_done;
  logic [WC_W-1:0]   w_wc_inc;
  logic              w_wc_full;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_fill_end;
  logic              w_run_end;

  // The word being accepted fills the memory when the incremented count reaches DEPTH.
  assign w_wc_inc  = r_wc + WC_W'(1);
  assign w_wc_full = (w_wc_inc == WC_W'(DEPTH));

  // Fill walks upward from the address just written; entering FILL, r_addr holds the
  // last program word's address, so the first fill address equals the word count.
  assign w_fill_addr = r_addr + ADDR_W'(1);
  assign w_fill_end  = (w_fill_addr == ADDR_W'(DEPTH - 1));

  assign w_run_end = (r_cycle == 16'(RUN_CYCLES - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection and state-decoded handshake/status outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load_ready = 1'b1;
        if (load_valid_i) begin
          // A full memory leaves nothing to fill, whether or not last was flagged.
          if (w_wc_full) begin
            w_state_nxt = S_RUN;
          end else if (load_last_i) begin
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (w_fill_end) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_start = 1'b1;
        if (w_run_end) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        w_done = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered imem write port, word/cycle counters and the sticky overflow flag.
  // The final load or fill write is presented in the cycle after its state exits,
  // i.e. it overlaps the first RUN cycle; the memory captures it at that cycle's end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wc    <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (load_valid_i) begin
            r_we   <= 1'b1;
            r_addr <= r_wc[ADDR_W-1:0];
            r_data <= load_data_i;
            r_wc   <= w_wc_inc;
            if (w_wc_full && !load_last_i) begin
              r_ovf <= 1'b1;
            end
          end
        end
        S_FILL: begin
          r_we   <= 1'b1;
          r_addr <= w_fill_addr;
          r_data <= '0;
        end
        S_RUN: begin
          // Freeze on the exit cycle so HALT reports RUN_CYCLES-1.
          if (!w_run_end && (r_cycle != 16'hFFFF)) begin
            r_cycle <= r_cycle + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign load_ready_o  = w_load_ready;
  assign start_o       = w_start;
  assign done_o        = w_done;
  assign imem_we_o     = r_we;
  assign imem_addr_o   = r_addr;
  assign imem_data_o   = r_data;
  assign word_count_o  = r_wc;
  assign cycle_count_o = r_cycle;
  assign overflow_o    = r_ovf;

  // The word counter can never run past the memory size.
  a_wc_bounded : assert property (@(posedge clk_i) word_count_o <= WC_W'(DEPTH));

  // Overflow is only ever raised by the DEPTH-th word.
  a_ovf_full : assert property (@(posedge clk_i) overflow_o |-> (word_count_o == WC_W'(DEPTH)));

  // HALT is terminal until reset.
  a_halt_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == S_HALT) |=> (r_state == S_HALT));

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              load_valid_i = 1'b0;
  logic [DATA_W-1:0] load_data_i = '0;
  logic              load_last_i = 1'b0;
  logic              load_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [DATA_W-1:0] imem_data_o;
  logic              start_o;
  logic              done_o;
  logic [ADDR_W:0]   word_count_o;
  logic [15:0]       cycle_count_o;
  logic              overflow_o;

  // second instance with a short run
  logic              v5 = 1'b0;
  logic [DATA_W-1:0] d5 = '0;
  logic              l5 = 1'b0;
  logic              r5, we5, st5, dn5, ov5;
  logic [ADDR_W-1:0] addr5;
  logic [DATA_W-1:0] dat5;
  logic [ADDR_W:0]   wc5;
  logic [15:0]       cc5;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_CYCLES(30)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .start_o(start_o), .done_o(done_o),
    .word_count_o(word_count_o), .cycle_count_o(cycle_count_o), .overflow_o(overflow_o)
  );

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RUN_CYCLES(5)) dut5 (
    .clk_i(clk_i), .rst_i(rst_i),
    .load_valid_i(v5), .load_data_i(d5), .load_last_i(l5),
    .load_ready_o(r5), .imem_we_o(we5), .imem_addr_o(addr5),
    .imem_data_o(dat5), .start_o(st5), .done_o(dn5),
    .word_count_o(wc5), .cycle_count_o(cc5), .overflow_o(ov5)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               sb_q[$];
  logic [DATA_W-1:0] mem[DEPTH];
  int                wr_cnt  = 0;
  int                st_cnt  = 0;
  int                st5_cnt = 0;
  int                m_wc    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: expected writes are queued at the handshake, popped as imem writes appear.
  always @(negedge clk_i) begin
    wr_t e;
    if (imem_we_o) begin
      wr_cnt++;
      mem[imem_addr_o] = imem_data_o;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected_write: got addr %0d data 0x%0h, expected no write", imem_addr_o, imem_data_o);
      end else begin
        e = sb_q.pop_front();
        check("sb_write", {imem_addr_o, imem_data_o}, {e.addr, e.data});
      end
    end
    if (start_o) st_cnt++;
    if (st5) st5_cnt++;
    if (!rst_i && load_valid_i && load_ready_o) begin
      sb_q.push_back(wr_t'{addr: ADDR_W'(m_wc), data: load_data_i});
      m_wc++;
      if (load_last_i && m_wc < DEPTH)
        for (int a = m_wc; a < DEPTH; a++) sb_q.push_back(wr_t'{addr: ADDR_W'(a), data: '0});
    end
    if (rst_i) begin
      sb_q.delete();
      m_wc    = 0;
      wr_cnt  = 0;
      st_cnt  = 0;
      st5_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    v5 = 1'b0;
    l5 = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    int t = 0;
    load_valid_i = 1'b1;
    load_data_i  = d;
    load_last_i  = l;
    while (!load_ready_o && t < 50) begin
      tick();
      t++;
    end
    if (!load_ready_o) begin
      n_chk++;
      $display("FAIL send_timeout: got ready 0 after %0d cycles, expected ready", t);
    end
    tick();
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while (!done_o && c < bound) begin
      tick();
      c++;
    end
    check("done_reached", done_o, 1'b1);
  endtask

  function automatic int zero_errs(input int from);
    int errs = 0;
    for (int a = from; a < DEPTH; a++) if (mem[a] !== '0) errs++;
    return errs;
  endfunction

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              l;
    logic              e_rdy;
    logic              e_we;
    logic [ADDR_W:0]   e_wc;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_dat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int errs;
    int found;

    tbl[0] = '{v:1'b1, d:32'hBAD0_BAD0, l:1'b0, e_rdy:1'b1, e_we:1'b0, e_wc:9'd0, e_addr:8'd0, e_dat:32'h0};
    tbl[1] = '{v:1'b1, d:32'h1111_0000, l:1'b0, e_rdy:1'b1, e_we:1'b1, e_wc:9'd1, e_addr:8'd0, e_dat:32'h1111_0000};
    tbl[2] = '{v:1'b0, d:32'h1111_0000, l:1'b0, e_rdy:1'b1, e_we:1'b0, e_wc:9'd1, e_addr:8'd0, e_dat:32'h0};
    tbl[3] = '{v:1'b1, d:32'h2222_0001, l:1'b1, e_rdy:1'b0, e_we:1'b1, e_wc:9'd2, e_addr:8'd1, e_dat:32'h2222_0001};
    tbl[4] = '{v:1'b0, d:32'h0,         l:1'b0, e_rdy:1'b0, e_we:1'b1, e_wc:9'd2, e_addr:8'd2, e_dat:32'h0};

    for (int a = 0; a < DEPTH; a++) mem[a] = 32'hDEAD_0000 + a;

    // reset state
    do_reset();
    check("reset_outputs",
          {load_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, done_o, word_count_o, cycle_count_o, overflow_o},
          128'd0);

    // three words, last on the third: program then 253 zero-fill writes, 30 run cycles
    send_word(32'hAAAA_0001, 1'b0);
    send_word(32'hBBBB_0002, 1'b0);
    send_word(32'hCCCC_0003, 1'b1);
    wait_done(1000);
    check("t1_start_cycles", st_cnt, 30);
    check("t1_fill_writes", wr_cnt - 3, 253);
    check("t1_counts", {word_count_o, cycle_count_o, overflow_o}, {9'd3, 16'd29, 1'b0});
    check("t1_prog", {mem[0], mem[1], mem[2]}, {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003});
    check("t1_zero_fill_errs", zero_errs(3), 0);
    check("t1_sb_drained", sb_q.size(), 0);
    repeat (5) tick();
    check("t1_halt_frozen", {start_o, done_o, cycle_count_o, load_ready_o}, {1'b0, 1'b1, 16'd29, 1'b0});

    // valid toggled 1,0,1 with a junk word offered during IDLE
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load_valid_i = tbl[i].v;
      load_data_i  = tbl[i].d;
      load_last_i  = tbl[i].l;
      tick();
      check($sformatf("t2_vec%0d", i),
            {load_ready_o, imem_we_o, word_count_o, imem_we_o ? imem_addr_o : 8'h0, imem_we_o ? imem_data_o : 32'h0},
            {tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_wc, tbl[i].e_addr, tbl[i].e_dat});
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    wait_done(1000);
    check("t2_total_writes", wr_cnt, 256);
    check("t2_prog", {mem[0], mem[1]}, {32'h1111_0000, 32'h2222_0001});
    check("t2_zero_fill_errs", zero_errs(2), 0);
    check("t2_sb_drained", sb_q.size(), 0);

    // 256 words without last: overflow, no fill, run next cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + i, 1'b0);
    check("t3_after_full", {overflow_o, load_ready_o, start_o, word_count_o}, {1'b1, 1'b0, 1'b1, 9'd256});
    load_valid_i = 1'b1;
    load_data_i  = 32'hFFFF_EEEE;
    repeat (3) tick();
    check("t3_extra_rejected", {load_ready_o, word_count_o}, {1'b0, 9'd256});
    load_valid_i = 1'b0;
    wait_done(1000);
    check("t3_total_writes", wr_cnt, 256);
    errs = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 32'h1000_0000 + a) errs++;
    check("t3_prog_errs", errs, 0);
    check("t3_ovf_sticky", overflow_o, 1'b1);

    // 256 words, last on the final one: no overflow, straight to run
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(32'h2000_0000 + i, (i == DEPTH - 1));
    check("t4_after_full", {overflow_o, load_ready_o, start_o, word_count_o}, {1'b0, 1'b0, 1'b1, 9'd256});
    wait_done(1000);
    check("t4_total_writes", wr_cnt, 256);
    check("t4_last_word", {mem[0], mem[255]}, {32'h2000_0000, 32'h2000_00FF});
    check("t4_start_cycles", st_cnt, 30);

    // reset in the middle of the fill, then a one-word program
    do_reset();
    send_word(32'h5555_0000, 1'b0);
    send_word(32'h5555_0001, 1'b1);
    found = 0;
    for (int t = 0; t < 400 && found == 0; t++) begin
      tick();
      if (imem_we_o && imem_addr_o == 8'd100) found = 1;
    end
    check("t5_reached_addr100", found, 1);
    rst_i = 1'b1;
    tick();
    check("t5_reset_outputs",
          {load_ready_o, imem_we_o, imem_addr_o, imem_data_o, start_o, done_o, word_count_o, cycle_count_o, overflow_o},
          128'd0);
    rst_i = 1'b0;
    send_word(32'h7777_ABCD, 1'b1);
    wait_done(1000);
    check("t5_word0", mem[0], 32'h7777_ABCD);
    check("t5_zero_fill_errs", zero_errs(1), 0);
    check("t5_total_writes", wr_cnt, 256);

    // short run length on the second instance
    do_reset();
    v5 = 1'b1;
    d5 = 32'h0BAD_F00D;
    l5 = 1'b1;
    for (int t = 0; t < 10 && !r5; t++) tick();
    check("t6_ready", r5, 1'b1);
    tick();
    v5 = 1'b0;
    l5 = 1'b0;
    for (int t = 0; t < 600 && !dn5; t++) tick();
    check("t6_done", dn5, 1'b1);
    check("t6_start_cycles", st5_cnt, 5);
    check("t6_halt_state", {st5, cc5, wc5, ov5}, {1'b0, 16'd4, 9'd1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
